// File: rtl/cnt_pkg.sv
// Shared types and constants for the loadable up/down counter.
package cnt_pkg;

   // Behaviour applied when the count sits on its terminal value
   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RELOAD  = 2'b11
   } mode_e;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/counter_updown_reload_if.sv
// Control/status bundle of the up/down counter: the master drives the
// controls and observes the count, the slave is the counter itself.
interface counter_updown_reload_if
   import cnt_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             dir;
   mode_e            mode;
   logic [WIDTH-1:0] result;
   logic             tc;
   logic             done;

   modport master (
      output en, load, load_val, dir, mode,
      input  result, tc, done
   );

   modport slave (
      input  en, load, load_val, dir, mode,
      output result, tc, done
   );

endinterface

// File: rtl/counter_next_val.sv
// Combinational next-count logic: given the current count, direction,
// mode and reload value, produces the value the count takes on an
// enabled edge and flags whether that edge is a terminal step.
module counter_next_val
   import cnt_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_result,
   input  logic             i_dir,
   input  mode_e            i_mode,
   input  logic [WIDTH-1:0] i_reloadVal,
   output logic [WIDTH-1:0] o_nextResult,
   output logic             o_terminalStep
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;

   logic [WIDTH-1:0] w_terminal;
   logic [WIDTH-1:0] w_stepped;

   // Terminal value is the end of the range we are heading towards
   assign w_terminal = (i_dir == DIR_UP) ? MAX_VAL : '0;
   assign w_stepped  = (i_dir == DIR_UP) ? (i_result + WIDTH'(1))
                                         : (i_result - WIDTH'(1));

   // Ordinary step away from the terminal, or mode-specific terminal step
   always_comb begin
      o_nextResult   = w_stepped;
      o_terminalStep = 1'b0;
      if (i_result == w_terminal) begin
         o_terminalStep = 1'b1;
         case (i_mode)
            MODE_WRAP:    o_nextResult = w_stepped;
            MODE_SAT:     o_nextResult = i_result;
            MODE_ONESHOT: o_nextResult = i_result;
            MODE_RELOAD:  o_nextResult = i_reloadVal;
            default:      o_nextResult = i_result;
         endcase
      end
   end

endmodule

// File: rtl/counter_updown_reload.sv
// Loadable up/down counter with wrap, saturate, one-shot and auto-reload
// terminal behaviour, a registered terminal-count pulse and a done flag.
module counter_updown_reload
   import cnt_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int RESET_VAL = 7
) (
   input logic                     clk,
   input logic                     reset,
   counter_updown_reload_if.slave  bus
);

   localparam logic [WIDTH-1:0] RESET_VEC = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_reloadReg;
   logic             r_tc;
   logic             r_done;

   logic [WIDTH-1:0] w_nextResult;
   logic             w_terminalStep;
   logic             w_step;

   counter_next_val #(
      .WIDTH (WIDTH)
   ) u_nextVal (
      .i_result       (r_result),
      .i_dir          (bus.dir),
      .i_mode         (bus.mode),
      .i_reloadVal    (r_reloadReg),
      .o_nextResult   (w_nextResult),
      .o_terminalStep (w_terminalStep)
   );

   // A count step happens only when enabled, not loading and not expired
   assign w_step = bus.en && !bus.load && !r_done;

   // Count and reload registers: load wins over counting, otherwise hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result    <= RESET_VEC;
         r_reloadReg <= RESET_VEC;
      end else if (bus.load) begin
         r_result    <= bus.load_val;
         r_reloadReg <= bus.load_val;
      end else if (w_step) begin
         r_result    <= w_nextResult;
      end
   end

   // Terminal pulse for one cycle after a terminal step; done latches on
   // a one-shot expiry and is only cleared by load or reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tc   <= 1'b0;
         r_done <= 1'b0;
      end else if (bus.load) begin
         r_tc   <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tc <= w_step && w_terminalStep;
         if (w_step && w_terminalStep && (bus.mode == MODE_ONESHOT)) begin
            r_done <= 1'b1;
         end
      end
   end

   assign bus.result = r_result;
   assign bus.tc     = r_tc;
   assign bus.done   = r_done;

endmodule

// File: tb/tb_counter_updown_reload.sv
// Testbench for counter_updown_reload (WIDTH=4, RESET_VAL=7): table of
// directed vectors, a hand-written asynchronous reset sequence, then
// random stimulus compared against a behavioural model.
module tb_counter_updown_reload;
   import cnt_pkg::*;

   localparam int W   = 4;
   localparam int RV  = 7;
   localparam int MOD = 1 << W;

   typedef struct {
      string      name;
      logic       load;
      logic       en;
      logic [3:0] loadVal;
      logic       dir;
      logic [1:0] mode;
      int         expResult;
      int         expTc;
      int         expDone;
   } vec_t;

   logic clk;
   logic reset;
   int   nChecks;
   int   nFails;

   // Behavioural model state
   int mRes;
   int mRel;
   int mTc;
   int mDone;

   vec_t vecs[$];

   counter_updown_reload_if #(.WIDTH(W)) bus ();

   counter_updown_reload #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mkVec(string nm, logic ld, logic e, int lv,
                                  logic d, mode_e m, int er, int et, int ed);
      vec_t v;
      v.name      = nm;
      v.load      = ld;
      v.en        = e;
      v.loadVal   = 4'(lv);
      v.dir       = d;
      v.mode      = 2'(m);
      v.expResult = er;
      v.expTc     = et;
      v.expDone   = ed;
      return v;
   endfunction

   task automatic modelReset();
      mRes  = RV;
      mRel  = RV;
      mTc   = 0;
      mDone = 0;
   endtask

   // Model of one clock edge, written directly from the counter's rules
   task automatic modelStep(input logic ld, input logic e, input int lv,
                            input logic d, input int m);
      int term;
      if (ld) begin
         mRes  = lv;
         mRel  = lv;
         mDone = 0;
         mTc   = 0;
      end else if (!e || mDone != 0) begin
         mTc = 0;
      end else begin
         term = d ? MOD - 1 : 0;
         if (mRes != term) begin
            mRes = d ? (mRes + 1) % MOD : (mRes + MOD - 1) % MOD;
            mTc  = 0;
         end else begin
            mTc = 1;
            case (m)
               0: mRes = d ? 0 : MOD - 1;
               1: mRes = mRes;
               2: mDone = 1;
               default: mRes = mRel;
            endcase
         end
      end
   endtask

   // Drive one edge's worth of inputs, advance the model, sample at +1
   task automatic applyStimulus(input logic ld, input logic e, input int lv,
                                input logic d, input int m);
      bus.load     = ld;
      bus.en       = e;
      bus.load_val = 4'(lv);
      bus.dir      = d;
      bus.mode     = mode_e'(m[1:0]);
      modelStep(ld, e, lv, d, m);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string nm, input int er, input int et,
                              input int ed);
      nChecks++;
      if (int'(bus.result) != er || int'(bus.tc) != et || int'(bus.done) != ed) begin
         nFails++;
         $display("[TB] FAIL %s: got result=%0d tc=%0d done=%0d, expected result=%0d tc=%0d done=%0d",
                  nm, bus.result, bus.tc, bus.done, er, et, ed);
      end
   endtask

   initial begin
      nChecks      = 0;
      nFails       = 0;
      reset        = 1'b1;
      bus.en       = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.dir      = DIR_DOWN;
      bus.mode     = MODE_WRAP;
      modelReset();

      // Asynchronous reset before any clock edge
      #2 reset = 1'b0;
      #1;
      checkOutput("reset_no_edge", RV, 0, 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_release", RV, 0, 0);

      // Reset dropped mid-count between edges
      applyStimulus(1'b1, 1'b0, 5, DIR_DOWN, 0);
      checkOutput("midcnt_load5", 5, 0, 0);
      applyStimulus(1'b0, 1'b1, 0, DIR_DOWN, 0);
      checkOutput("midcnt_dn1", 4, 0, 0);
      applyStimulus(1'b0, 1'b1, 0, DIR_DOWN, 0);
      checkOutput("midcnt_dn2", 3, 0, 0);
      bus.en = 1'b0;
      #2 reset = 1'b0;
      modelReset();
      #1;
      checkOutput("midcnt_async_reset", RV, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midcnt_after_release", RV, 0, 0);

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         int exp9 [9] = '{6, 5, 4, 3, 2, 1, 0, 15, 14};
         vecs.push_back(mkVec("wrap_down", 1'b0, 1'b1, 0, DIR_DOWN, MODE_WRAP,
                              exp9[i], (i == 7) ? 1 : 0, 0));
      end
      vecs.push_back(mkVec("sat_load13",  1'b1, 1'b0, 13, DIR_UP, MODE_SAT, 13, 0, 0));
      vecs.push_back(mkVec("sat_up1",     1'b0, 1'b1, 0,  DIR_UP, MODE_SAT, 14, 0, 0));
      vecs.push_back(mkVec("sat_up2",     1'b0, 1'b1, 0,  DIR_UP, MODE_SAT, 15, 0, 0));
      vecs.push_back(mkVec("sat_up3",     1'b0, 1'b1, 0,  DIR_UP, MODE_SAT, 15, 1, 0));
      vecs.push_back(mkVec("sat_up4",     1'b0, 1'b1, 0,  DIR_UP, MODE_SAT, 15, 1, 0));
      vecs.push_back(mkVec("os_load2",    1'b1, 1'b0, 2,  DIR_DOWN, MODE_ONESHOT, 2, 0, 0));
      vecs.push_back(mkVec("os_dn1",      1'b0, 1'b1, 0,  DIR_DOWN, MODE_ONESHOT, 1, 0, 0));
      vecs.push_back(mkVec("os_dn2",      1'b0, 1'b1, 0,  DIR_DOWN, MODE_ONESHOT, 0, 0, 0));
      vecs.push_back(mkVec("os_expire",   1'b0, 1'b1, 0,  DIR_DOWN, MODE_ONESHOT, 0, 1, 1));
      vecs.push_back(mkVec("os_hold1",    1'b0, 1'b1, 0,  DIR_DOWN, MODE_ONESHOT, 0, 0, 1));
      vecs.push_back(mkVec("os_hold2",    1'b0, 1'b1, 0,  DIR_DOWN, MODE_ONESHOT, 0, 0, 1));
      vecs.push_back(mkVec("os_load5",    1'b1, 1'b0, 5,  DIR_DOWN, MODE_ONESHOT, 5, 0, 0));
      vecs.push_back(mkVec("rl_load3",    1'b1, 1'b0, 3,  DIR_DOWN, MODE_RELOAD, 3, 0, 0));
      vecs.push_back(mkVec("rl_dn1",      1'b0, 1'b1, 0,  DIR_DOWN, MODE_RELOAD, 2, 0, 0));
      vecs.push_back(mkVec("rl_dn2",      1'b0, 1'b1, 0,  DIR_DOWN, MODE_RELOAD, 1, 0, 0));
      vecs.push_back(mkVec("rl_dn3",      1'b0, 1'b1, 0,  DIR_DOWN, MODE_RELOAD, 0, 0, 0));
      vecs.push_back(mkVec("rl_reload",   1'b0, 1'b1, 0,  DIR_DOWN, MODE_RELOAD, 3, 1, 0));
      vecs.push_back(mkVec("rl_dn4",      1'b0, 1'b1, 0,  DIR_DOWN, MODE_RELOAD, 2, 0, 0));
      vecs.push_back(mkVec("ld_en_same",  1'b1, 1'b1, 9,  DIR_DOWN, MODE_WRAP, 9, 0, 0));
      vecs.push_back(mkVec("hold1",       1'b0, 1'b0, 0,  DIR_DOWN, MODE_WRAP, 9, 0, 0));
      vecs.push_back(mkVec("hold2",       1'b0, 1'b0, 0,  DIR_DOWN, MODE_WRAP, 9, 0, 0));
      vecs.push_back(mkVec("hold3",       1'b0, 1'b0, 0,  DIR_DOWN, MODE_WRAP, 9, 0, 0));
      vecs.push_back(mkVec("wrapup_ld15", 1'b1, 1'b0, 15, DIR_UP, MODE_WRAP, 15, 0, 0));
      vecs.push_back(mkVec("wrapup_tc",   1'b0, 1'b1, 0,  DIR_UP, MODE_WRAP, 0, 1, 0));
      vecs.push_back(mkVec("rlup_ld14",   1'b1, 1'b0, 14, DIR_UP, MODE_RELOAD, 14, 0, 0));
      vecs.push_back(mkVec("rlup_1",      1'b0, 1'b1, 0,  DIR_UP, MODE_RELOAD, 15, 0, 0));
      vecs.push_back(mkVec("rlup_reload", 1'b0, 1'b1, 0,  DIR_UP, MODE_RELOAD, 14, 1, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].load, vecs[i].en, int'(vecs[i].loadVal),
                       vecs[i].dir, int'(vecs[i].mode));
         checkOutput(vecs[i].name, vecs[i].expResult, vecs[i].expTc,
                     vecs[i].expDone);
      end

      // Random stimulus against the behavioural model
      for (int i = 0; i < 400; i++) begin
         logic ld;
         logic e;
         logic d;
         int   lv;
         int   m;
         ld = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         d  = 1'($urandom_range(0, 1));
         lv = $urandom_range(0, MOD - 1);
         m  = $urandom_range(0, 3);
         applyStimulus(ld, e, lv, d, m);
         checkOutput("random", mRes, mTc, mDone);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
